// File: rtl/ewh_target_pkg.sv
// Shared types for the laser-glove target manager: channel state encoding and width helpers.
package ewh_target_pkg;

    localparam int unsigned CH_STATE_W = 2;

    typedef enum logic [CH_STATE_W-1:0] {
        CH_IDLE    = 2'd0,
        CH_ARMED   = 2'd1,
        CH_QUALIFY = 2'd2
    } ch_state_e;

    // Index width for a selector over n items, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/target_channel.sv
// One target channel: arm latch, lifetime countdown, sensor debounce, hit/miss strobes.
module target_channel
    import ewh_target_pkg::*;
#(
    parameter int unsigned NUM_SENSORS = 10,
    parameter int unsigned IDX_W       = 4,
    parameter int unsigned TMO_W       = 24,
    parameter int unsigned DEBOUNCE    = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   arm_go,
    input  logic [IDX_W-1:0]       arm_idx,
    input  logic [TMO_W-1:0]       arm_timeout,
    input  logic [NUM_SENSORS-1:0] sensor_s,
    output logic                   idle_c,
    output logic                   hit_c,
    output logic                   miss_c,
    output logic [IDX_W-1:0]       target_idx,
    output logic                   target_active,
    output logic                   hit_pulse,
    output logic                   miss_pulse
);

    localparam int unsigned DEB_W = $clog2(DEBOUNCE + 1);
    localparam int unsigned PAD_W = 1 << IDX_W;

    ch_state_e          state_q, state_d;
    logic [TMO_W-1:0]   cnt_q, cnt_d;
    logic [DEB_W-1:0]   deb_q, deb_d;
    logic [DEB_W-1:0]   deb_inc;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               active_q, active_d;
    logic               hit_pulse_q, miss_pulse_q;
    logic [PAD_W-1:0]   sensor_pad;
    logic               sample;

    // Pad so any index value selects a defined bit; arm validation keeps idx in range.
    assign sensor_pad = PAD_W'(sensor_s);
    assign sample     = sensor_pad[idx_q];
    assign deb_inc    = deb_q + DEB_W'(1);
    assign idle_c     = (state_q == CH_IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        deb_d   = deb_q;
        idx_d   = idx_q;
        hit_c   = 1'b0;
        miss_c  = 1'b0;
        case (state_q)
            CH_IDLE: begin
                if (arm_go) begin
                    state_d = CH_ARMED;
                    idx_d   = arm_idx;
                    cnt_d   = arm_timeout;
                    deb_d   = '0;
                end
            end
            CH_ARMED, CH_QUALIFY: begin
                cnt_d = cnt_q - TMO_W'(1);
                if (sample) begin
                    if (deb_inc == DEB_W'(DEBOUNCE)) begin
                        hit_c   = 1'b1;
                        state_d = CH_IDLE;
                        deb_d   = '0;
                    end else begin
                        deb_d   = deb_inc;
                        state_d = CH_QUALIFY;
                    end
                end else begin
                    deb_d   = '0;
                    state_d = CH_ARMED;
                end
                // A hit on the expiry edge takes precedence over the miss.
                if (!hit_c && (cnt_q == TMO_W'(1))) begin
                    miss_c  = 1'b1;
                    state_d = CH_IDLE;
                    deb_d   = '0;
                end
            end
            default: state_d = CH_IDLE;
        endcase
        active_d = (state_d != CH_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= CH_IDLE;
            cnt_q        <= '0;
            deb_q        <= '0;
            idx_q        <= '0;
            active_q     <= 1'b0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            deb_q        <= deb_d;
            idx_q        <= idx_d;
            active_q     <= active_d;
            hit_pulse_q  <= hit_c;
            miss_pulse_q <= miss_c;
        end
    end

    assign target_idx    = idx_q;
    assign target_active = active_q;
    assign hit_pulse     = hit_pulse_q;
    assign miss_pulse    = miss_pulse_q;

endmodule

// File: rtl/target_array_ctrl.sv
// Target manager top: sensor synchroniser, arm decode/validation, saturating score.
// Build option MISS_PENALTY_EN: each timeout subtracts MISS_POINTS from the score.
module target_array_ctrl
    import ewh_target_pkg::*;
#(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned NUM_SENSORS = 10,
    parameter int unsigned IDX_W       = 4,
    parameter int unsigned TMO_W       = 24,
    parameter int unsigned DEBOUNCE    = 4,
    parameter int unsigned SCORE_W     = 16,
    parameter int unsigned HIT_POINTS  = 1,
    parameter int unsigned MISS_POINTS = 1,
    localparam int unsigned CH_W       = clog2_min1(NUM_CH)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_SENSORS-1:0]   photo_array,
    input  logic                     arm_valid,
    input  logic [CH_W-1:0]          arm_ch,
    input  logic [IDX_W-1:0]         arm_idx,
    input  logic [TMO_W-1:0]         arm_timeout,
    output logic                     arm_ready,
    output logic                     arm_err,
    input  logic                     clear_score,
    output logic [NUM_CH*IDX_W-1:0]  target_idx,
    output logic [NUM_CH-1:0]        target_active,
    output logic [NUM_CH-1:0]        hit_pulse,
    output logic [NUM_CH-1:0]        miss_pulse,
    output logic [SCORE_W-1:0]       score
);

    localparam int unsigned ACC_W = SCORE_W + 34;

    logic [NUM_SENSORS-1:0] sync1_q, sync1_d;
    logic [NUM_SENSORS-1:0] sync2_q, sync2_d;
    logic                   arm_err_q, arm_err_d;
    logic [SCORE_W-1:0]     score_q, score_d;
    logic                   arm_ok_c;
    logic [NUM_CH-1:0]      idle_c;
    logic [NUM_CH-1:0]      hit_c;
    logic [NUM_CH-1:0]      miss_c;
    logic [ACC_W-1:0]       nhit;
    logic [ACC_W-1:0]       acc;

    // arm_ready is combinational from arm_ch; out-of-range channels read as busy.
    always_comb begin
        arm_ready = 1'b0;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            if (arm_ch == CH_W'(c)) arm_ready = idle_c[c];
        end
    end

    assign arm_ok_c = arm_valid && arm_ready
                   && (32'(arm_idx) < NUM_SENSORS)
                   && (arm_timeout != '0);

    for (genvar c = 0; c < int'(NUM_CH); c++) begin : g_ch
        target_channel #(
            .NUM_SENSORS (NUM_SENSORS),
            .IDX_W       (IDX_W),
            .TMO_W       (TMO_W),
            .DEBOUNCE    (DEBOUNCE)
        ) u_ch (
            .clock         (clock),
            .reset         (reset),
            .arm_go        (arm_ok_c && (arm_ch == CH_W'(c))),
            .arm_idx       (arm_idx),
            .arm_timeout   (arm_timeout),
            .sensor_s      (sync2_q),
            .idle_c        (idle_c[c]),
            .hit_c         (hit_c[c]),
            .miss_c        (miss_c[c]),
            .target_idx    (target_idx[c*IDX_W +: IDX_W]),
            .target_active (target_active[c]),
            .hit_pulse     (hit_pulse[c]),
            .miss_pulse    (miss_pulse[c])
        );
    end

`ifdef MISS_PENALTY_EN
    logic [ACC_W-1:0] nmiss;
`else
    logic unused_miss;
    assign unused_miss = ^{miss_c, 32'(MISS_POINTS)};
`endif

    // Hits and misses of the same edge are netted before clamping to [0, 2^SCORE_W-1].
    always_comb begin
        nhit = '0;
        for (int c = 0; c < int'(NUM_CH); c++) nhit = nhit + ACC_W'(hit_c[c]);
        acc = ACC_W'(score_q) + ACC_W'(HIT_POINTS) * nhit;
`ifdef MISS_PENALTY_EN
        nmiss = '0;
        for (int c = 0; c < int'(NUM_CH); c++) nmiss = nmiss + ACC_W'(miss_c[c]);
        acc = acc - ACC_W'(MISS_POINTS) * nmiss;
`endif
        if (clear_score) begin
            score_d = '0;
        end else if (acc[ACC_W-1]) begin
            score_d = '0;
        end else if (acc > ACC_W'({SCORE_W{1'b1}})) begin
            score_d = {SCORE_W{1'b1}};
        end else begin
            score_d = acc[SCORE_W-1:0];
        end
    end

    always_comb begin
        sync1_d   = photo_array;
        sync2_d   = sync1_q;
        arm_err_d = arm_valid && !arm_ok_c;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            arm_err_q <= 1'b0;
            score_q   <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            arm_err_q <= arm_err_d;
            score_q   <= score_d;
        end
    end

    assign arm_err = arm_err_q;
    assign score   = score_q;

endmodule

// File: tb/tb_target_array_ctrl.sv
// Bench for target_array_ctrl: arm-vector table plus hand sequences for timing corners.
module tb_target_array_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [9:0]  photo_array;
    logic        arm_valid;
    logic [0:0]  arm_ch;
    logic [3:0]  arm_idx;
    logic [23:0] arm_timeout;
    logic        arm_ready;
    logic        arm_err;
    logic        clear_score;
    logic [7:0]  target_idx;
    logic [1:0]  target_active;
    logic [1:0]  hit_pulse;
    logic [1:0]  miss_pulse;
    logic [3:0]  score;

    target_array_ctrl #(
        .NUM_CH(2), .NUM_SENSORS(10), .IDX_W(4), .TMO_W(24), .DEBOUNCE(4),
        .SCORE_W(4), .HIT_POINTS(1), .MISS_POINTS(1)
    ) dut (
        .clock(clock), .reset(reset), .photo_array(photo_array),
        .arm_valid(arm_valid), .arm_ch(arm_ch), .arm_idx(arm_idx),
        .arm_timeout(arm_timeout), .arm_ready(arm_ready), .arm_err(arm_err),
        .clear_score(clear_score), .target_idx(target_idx),
        .target_active(target_active), .hit_pulse(hit_pulse),
        .miss_pulse(miss_pulse), .score(score)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        valid;
        logic [0:0]  ch;
        logic [3:0]  idx;
        logic [23:0] tmo;
        logic        exp_ready;
        logic        exp_err;
    } arm_vec_t;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    arm_vec_t tbl[6];
    sb_t      sb_q[$];
    int       n_cmp = 0;
    int       n_bad = 0;
    int       cyc = 0;
    int       hit_seen[2];
    int       miss_seen[2];
    int       last_hit[2];
    int       last_miss[2];
    int       acc_cyc, a_cyc, y_cyc, h0, h1, m0, m1;
    int       exp_score;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic sb_push(input string name, input logic [31:0] exp);
        sb_t e;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] act);
        sb_t e;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_empty: got %0d expected none", act);
        end else begin
            e = sb_q.pop_front();
            chk(e.name, act, e.exp);
        end
    endtask

    // Advance one edge and log strobes seen just after it.
    task automatic tick();
        @(posedge clock);
        cyc++;
        #1;
        for (int c = 0; c < 2; c++) begin
            if (hit_pulse[c])  begin hit_seen[c]++;  last_hit[c]  = cyc; end
            if (miss_pulse[c]) begin miss_seen[c]++; last_miss[c] = cyc; end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic arm(input int ch, input int idx, input int tmo);
        arm_valid   = 1'b1;
        arm_ch      = 1'(ch);
        arm_idx     = 4'(idx);
        arm_timeout = 24'(tmo);
        tick();
        arm_valid   = 1'b0;
    endtask

    task automatic wait_idle(input logic [1:0] mask, input int bound);
        int n = 0;
        while (((target_active & mask) != 2'b00) && (n < bound)) begin
            tick();
            n++;
        end
        if ((target_active & mask) != 2'b00) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_idle: got active %0d expected 0 within %0d cycles", target_active, bound);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int c = 0; c < 2; c++) begin
            hit_seen[c] = 0; miss_seen[c] = 0; last_hit[c] = -1; last_miss[c] = -1;
        end
        tbl[0] = '{1'b1, 1'b0, 4'd12, 24'd5,  1'b1, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 4'd3,  24'd0,  1'b1, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 4'd10, 24'd5,  1'b1, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 4'd12, 24'd0,  1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 4'd3,  24'd20, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 4'd9,  24'd7,  1'b0, 1'b1};

        reset = 1'b1; photo_array = '1; arm_valid = 1'b0; arm_ch = '0;
        arm_idx = '0; arm_timeout = '0; clear_score = 1'b0;
        ticks(3);
        chk("rst_active", 32'(target_active), 0);
        chk("rst_idx", 32'(target_idx), 0);
        chk("rst_hit", 32'(hit_pulse), 0);
        chk("rst_miss", 32'(miss_pulse), 0);
        chk("rst_err", 32'(arm_err), 0);
        chk("rst_score", 32'(score), 0);
        photo_array = '0;
        reset = 1'b0;
        ticks(3);

        // Arm validation table; entry 4 starts the 20-cycle timeout on ch0.
        for (int i = 0; i < 6; i++) begin
            arm_valid = tbl[i].valid; arm_ch = tbl[i].ch;
            arm_idx = tbl[i].idx; arm_timeout = tbl[i].tmo;
            #1;
            chk($sformatf("arm_ready[%0d]", i), 32'(arm_ready), 32'(tbl[i].exp_ready));
            sb_push($sformatf("arm_err[%0d]", i), 32'(tbl[i].exp_err));
            tick();
            sb_pop(32'(arm_err));
            if (i == 4) acc_cyc = cyc;
        end
        arm_valid = 1'b0;
        chk("tmo_idx", 32'(target_idx[3:0]), 3);
        chk("tmo_active", 32'(target_active[0]), 1);
        wait_idle(2'b01, 60);
        chk("tmo_active_cycles", 32'(cyc - acc_cyc), 20);
        chk("tmo_miss_pulse", 32'(miss_pulse[0]), 1);
        chk("tmo_score", 32'(score), 0);
        tick();
        chk("tmo_miss_one_cycle", 32'(miss_pulse[0]), 0);
        chk("tmo_hit_none", 32'(hit_seen[0]), 0);

        // Debounce: 3-high burst is rejected, hit lands 4 synchronised highs into the 6-high burst.
        arm(1, 7, 1000);
        photo_array[7] = 1'b1; ticks(3);
        photo_array[7] = 1'b0; ticks(4);
        y_cyc = cyc;
        sb_push("deb_hit_cycle", 32'(y_cyc + 6));
        photo_array[7] = 1'b1; ticks(6);
        photo_array[7] = 1'b0; ticks(4);
        sb_pop(32'(last_hit[1]));
        chk("deb_hit_count", 32'(hit_seen[1]), 1);
        chk("deb_score", 32'(score), 1);
        chk("deb_active", 32'(target_active[1]), 0);
        chk("deb_miss_none", 32'(miss_seen[1]), 0);

        // Collision on idx5; ch1 expires on the hit edge.
        h0 = hit_seen[0]; h1 = hit_seen[1]; m1 = miss_seen[1];
        arm(0, 5, 100);
        arm(1, 5, 6);
        a_cyc = cyc;
        photo_array[5] = 1'b1;
        ticks(8);
        chk("col_hits0", 32'(hit_seen[0] - h0), 1);
        chk("col_hits1", 32'(hit_seen[1] - h1), 1);
        chk("col_hit_cycle0", 32'(last_hit[0]), 32'(a_cyc + 6));
        chk("col_hit_cycle1", 32'(last_hit[1]), 32'(a_cyc + 6));
        chk("col_no_miss", 32'(miss_seen[1] - m1), 0);
        chk("col_score", 32'(score), 3);

        // Saturation at 15 with SCORE_W=4, sensor 5 held high.
        exp_score = 3;
        for (int i = 0; i < 7; i++) begin
            arm(0, 5, 50);
            arm(1, 5, 50);
            wait_idle(2'b11, 20);
            exp_score = (exp_score + 2 > 15) ? 15 : exp_score + 2;
            sb_push($sformatf("sat_score[%0d]", i), 32'(exp_score));
            sb_pop(32'(score));
        end
        arm(0, 5, 50);
        ticks(3);
        clear_score = 1'b1;
        tick();
        clear_score = 1'b0;
        chk("clr_hit_pulse", 32'(hit_pulse[0]), 1);
        chk("clr_score", 32'(score), 0);

        // Miss handling, with and without the penalty build.
        photo_array = '0;
        ticks(3);
        m0 = miss_seen[0];
        arm(0, 2, 3);
        wait_idle(2'b01, 10);
        tick();
        chk("pen_miss_seen", 32'(miss_seen[0] - m0), 1);
        chk("pen_floor_score", 32'(score), 0);
        photo_array[5] = 1'b1;
        ticks(2);
        for (int i = 0; i < 5; i++) begin
            arm(0, 5, 50);
            wait_idle(2'b01, 10);
        end
        chk("pen_score5", 32'(score), 5);
        arm(0, 5, 100);
        arm(1, 4, 3);
        wait_idle(2'b11, 10);
        tick();
        chk("pen_same_edge", 32'(last_hit[0]), 32'(last_miss[1]));
`ifdef MISS_PENALTY_EN
        chk("pen_net_score", 32'(score), 5);
`else
        chk("pen_net_score", 32'(score), 6);
`endif
        arm(1, 4, 2);
        wait_idle(2'b10, 10);
        tick();
`ifdef MISS_PENALTY_EN
        chk("pen_lone_miss", 32'(score), 4);
`else
        chk("pen_lone_miss", 32'(score), 6);
`endif

        // Reset mid-operation aborts without strobes.
        m1 = miss_seen[1];
        arm(1, 4, 100);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_active", 32'(target_active), 0);
        chk("mid_rst_score", 32'(score), 0);
        ticks(3);
        chk("mid_rst_no_miss", 32'(miss_seen[1] - m1), 0);
        chk("mid_rst_ready", 32'(arm_ready), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/target_array_ctrl.md
Name: target_array_ctrl

Overview:
- Hardware target manager for the laser-glove game: arms up to NUM_CH concurrent targets on a NUM_SENSORS photodiode array, qualifies hits, detects timeouts, keeps the score.
- Takes over, in hardware, the per-target hit latching and countdown that software does today, so the core only issues arm commands and reads score/status.
- Sits between the processor's memory-mapped I/O and the photo_array pins; score feeds score_converter.

Parameters:
- NUM_CH, 2, number of independent target channels
- NUM_SENSORS, 10, photodiode count; valid target indices 0..NUM_SENSORS-1
- IDX_W, 4, target index width; IDX_W >= clog2(NUM_SENSORS)
- TMO_W, 24, timeout counter width
- DEBOUNCE, 4, consecutive synchronised high samples required for a hit (>=1)
- SCORE_W, 16, score width
- HIT_POINTS, 1, added per hit
- MISS_POINTS, 1, subtracted per miss (MISS_PENALTY_EN only)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- photo_array  in  NUM_SENSORS  asynchronous sensor inputs
- arm_valid  in  1  arm request
- arm_ch  in  clog2(NUM_CH)  channel to arm
- arm_idx  in  IDX_W  sensor index to light
- arm_timeout  in  TMO_W  lifetime in cycles
- arm_ready  out  1  selected arm_ch is IDLE (combinational from arm_ch)
- arm_err  out  1  one-cycle pulse, arm rejected
- clear_score  in  1  zero the score
- target_idx  out  NUM_CH*IDX_W  per-channel index, channel c at [c*IDX_W +: IDX_W]
- target_active  out  NUM_CH  channel armed
- hit_pulse  out  NUM_CH  one-cycle hit strobe
- miss_pulse  out  NUM_CH  one-cycle timeout strobe
- score  out  SCORE_W  current score

Behaviour:
- Reset: all channels IDLE; target_idx=0, target_active=0, hit_pulse=0, miss_pulse=0, arm_err=0, score=0; synchroniser flops cleared. Reset mid-operation aborts every channel with no pulses.
- photo_array passes through a 2-flop synchroniser; all hit logic uses the synchronised vector.
- Arm accepted on an edge when arm_valid && arm_ready && arm_idx<NUM_SENSORS && arm_timeout!=0. Next cycle: target_active[c]=1, target_idx latched, countdown=arm_timeout, debounce count=0. Otherwise, if arm_valid: arm_err=1 next cycle, no state change.
- Channel FSM: IDLE -> ARMED (accepted arm); ARMED -> QUALIFY (sensor high); QUALIFY -> ARMED (sensor low, debounce count cleared); QUALIFY/ARMED -> IDLE on hit or timeout.
- Countdown decrements every cycle in ARMED and QUALIFY; unarmed, target_active is high exactly arm_timeout cycles.
- Hit: DEBOUNCE consecutive synchronised highs on the channel's sensor. DEBOUNCE=1 hits on the first high sample. hit_pulse high one cycle, coincident with target_active falling and score update.
- Timeout: countdown expiry -> miss_pulse one cycle in the first cycle target_active is low.
- Hit and expiry on the same edge: hit wins, no miss.
- Two channels on the same index: legal; each qualifies independently and each scores.
- Score: add HIT_POINTS × (hits this cycle); saturate at 2^SCORE_W-1, no wrap. clear_score forces 0 and overrides same-cycle hits.
- A freshly IDLE channel is re-armable on the next edge.

Optional Feature:
- MISS_PENALTY_EN: each miss subtracts MISS_POINTS. Same-cycle hits and misses are netted; the result floors at 0 and saturates at the top.
- Without the macro: misses never change score; MISS_POINTS is unused.

Decomposition:
- Package ewh_target_pkg: channel state enum (IDLE, ARMED, QUALIFY) and state encoding width.
- Sub-module target_channel, instantiated NUM_CH times via generate: FSM, countdown, debounce counter, index register, pulse outputs.
- Top level holds the synchroniser, arm decode/validation, and the saturating score adder.

Test Plan:
- Timeout: arm ch0 idx3 timeout 20, sensors low -> target_active[0] high 20 cycles, miss_pulse[0] one cycle after, score unchanged at 0.
- Debounced hit: arm ch1 idx7 timeout 1000, DEBOUNCE=4; photo_array[7] high 3 cycles, low, then high 6 -> exactly one hit_pulse[1] 4 synchronised highs into the second burst; score 0->1.
- Bad arm: arm_idx=12 -> arm_err pulse. Arm_timeout=0 -> arm_err pulse. Re-arm an ARMED ch0 -> arm_ready=0, arm_err pulse, original timeout intact.
- Collision: ch0 and ch1 both on idx5; sensor high; hit on same edge as ch1 expiry -> two hit_pulses, no miss_pulse, score +2.
- Saturation/clear: SCORE_W=4, score 15, hit -> stays 15; clear_score with concurrent hit -> 0.
- Penalty: with MISS_PENALTY_EN, score 0 plus a miss -> 0. Score 5 with one hit and one miss on the same edge -> 5. Without the macro, a miss at score 5 -> 5.
